edge_detector: RTL and testbench

Single-bit edge detector with an optional input synchronizer and a run-time edge-type select. It samples a level input `a_i` on `clk` and emits one-cycle pulses on `rising_edge_o` and `falling_edge_o`. Typical uses are button, strobe and handshake conditioning, where a level change must become a single-cycle event. The outputs are registered, so they are glitch-free for downstream logic.

---
 rtl/edge_detector_if.sv | 29 ++
 rtl/edge_detector.sv | 71 +++++++
 tb/tb_edge_detector.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/edge_detector_if.sv
// Signal bundle for the edge detector: the monitored level, the edge-type
// mask and the two registered pulse outputs.
//
// Handshake semantics: there is no valid/ready pair here. The source
// presents a_i and edge_type_i as levels that are sampled on every rising
// clock edge. The detector answers with one-cycle pulses that carry no
// backpressure: a pulse that the consumer does not sample is lost.
interface edge_detector_if;
  logic       a_i;
  logic [1:0] edge_type_i;
  logic       rising_edge_o;
  logic       falling_edge_o;

  // Stimulus side: drives the level and the mask, observes the pulses.
  modport master (
    output a_i,
    output edge_type_i,
    input  rising_edge_o,
    input  falling_edge_o
  );

  // Detector side.
  modport slave (
    input  a_i,
    input  edge_type_i,
    output rising_edge_o,
    output falling_edge_o
  );
endinterface

// File: rtl/edge_detector.sv
// Single-bit edge detector. An optional synchronizer chain is followed by a
// history flop. Registered rise/fall pulses are gated by a run-time mask.
// Latency from the first posedge that samples a new level to the pulse is
// SYNC_STAGES posedges. Each transition produces a pulse exactly one cycle
// wide.
module edge_detector #(
  parameter int SYNC_STAGES = 2  // 0..4; 0 treats a_i as already synchronous
) (
  input logic            clk,
  input logic            reset,
  edge_detector_if.slave bus
);

  logic s;      // synchronized view of a_i
  logic prev;   // s as seen on the previous posedge
  logic rise;
  logic fall;

  generate
    if (SYNC_STAGES == 0) begin : g_no_sync
      assign s = bus.a_i;
    end else begin : g_sync
      // Flop 0 is the only flop that samples the asynchronous a_i. With two
      // or more stages, the back end flow tags this chain as a synchronizer.
      logic [SYNC_STAGES-1:0] sync_q;

      // Shift a_i through the synchronizer chain; reset clears every stage.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= bus.a_i;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Track the previous synchronized level. It resets to 0, so an input held
  // high through reset release yields one rising pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= 1'b0;
    end else begin
      prev <= s;
    end
  end

  // Raw edge terms; they are mutually exclusive by construction.
  always_comb begin
    rise = s & ~prev;
    fall = ~s & prev;
  end

  // Register the masked pulses. The mask is sampled on this same edge, so a
  // masked edge is dropped and is not deferred.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rising_edge_o  <= 1'b0;
      bus.falling_edge_o <= 1'b0;
    end else begin
      bus.rising_edge_o  <= rise & bus.edge_type_i[0];
      bus.falling_edge_o <= fall & bus.edge_type_i[1];
    end
  end

endmodule

// File: tb/tb_edge_detector.sv
// Testbench for edge_detector. Two instances, with SYNC_STAGES = 0 and 2,
// share one stimulus stream. Each instance is compared every cycle against
// a history-based reference model. Table vectors and hand-written sequences
// cover toggles, masks and the reset corner cases.
module tb_edge_detector;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  edge_detector_if bus0();
  edge_detector_if bus2();

  edge_detector #(.SYNC_STAGES(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  edge_detector #(.SYNC_STAGES(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- reference model + scoreboard ----------------
  // samp_q[j] is the a_i value sampled j posedges ago (j = 0 is the current
  // posedge). Samples from before the last reset count as 0. A pulse for a
  // delay of S appears when the sample S posedges back differs from the one
  // just before it. Each entry of exp_q holds {rise0, fall0, rise2, fall2}.
  logic       samp_q[$];
  logic [3:0] exp_q[$];

  function automatic logic smp(int j);
    if (j < samp_q.size()) return samp_q[j];
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    logic [1:0] m;
    m = bus0.edge_type_i;
    if (reset) begin
      samp_q.delete();
      exp_q.push_back(4'b0000);
    end else begin
      samp_q.push_front(bus0.a_i);
      if (samp_q.size() > 8) void'(samp_q.pop_back());
      exp_q.push_back({ smp(0) & ~smp(1) & m[0],
                        ~smp(0) & smp(1) & m[1],
                        smp(2) & ~smp(3) & m[0],
                        ~smp(2) & smp(3) & m[1] });
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b expected=%0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [3:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL model_empty actual=0 expected=1 at %0t", $time);
      return;
    end
    e = exp_q[$];
    exp_q.delete();
    chk("model_rise0", bus0.rising_edge_o,  e[3]);
    chk("model_fall0", bus0.falling_edge_o, e[2]);
    chk("model_rise2", bus2.rising_edge_o,  e[1]);
    chk("model_fall2", bus2.falling_edge_o, e[0]);
    chk("excl0", bus0.rising_edge_o & bus0.falling_edge_o, 1'b0);
    chk("excl2", bus2.rising_edge_o & bus2.falling_edge_o, 1'b0);
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change at the negedge. Outputs are checked at the following
  // negedge, one posedge later.
  task automatic step(input logic a, input logic [1:0] m);
    bus0.a_i = a;
    bus0.edge_type_i = m;
    bus2.a_i = a;
    bus2.edge_type_i = m;
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic settle_low(input logic [1:0] m);
    for (int i = 0; i < 4; i++) step(1'b0, m);
  endtask

  // a_i goes high at c = 0 for 3 cycles, then low. With two sync stages
  // the rise pulse follows the posedge at c = 2 and the fall pulse follows
  // the posedge at c = 5.
  task automatic run_pattern(input logic [1:0] m);
    settle_low(m);
    for (int c = 0; c < 7; c++) begin
      step((c < 3) ? 1'b1 : 1'b0, m);
      chk($sformatf("pat%0b_rise2_c%0d", m, c), bus2.rising_edge_o,  (c == 2) & m[0]);
      chk($sformatf("pat%0b_fall2_c%0d", m, c), bus2.falling_edge_o, (c == 5) & m[1]);
    end
  endtask

  typedef struct {
    logic       a;
    logic [1:0] m;
    logic       r;   // expected rising_edge_o of the SYNC_STAGES = 0 instance
    logic       f;   // expected falling_edge_o of the SYNC_STAGES = 0 instance
  } vec_t;

  vec_t tbl[7];

  // ---------------- test sequence ----------------
  initial begin
    logic [1:0] m;

    bus0.a_i = 1'b0; bus0.edge_type_i = 2'b11;
    bus2.a_i = 1'b0; bus2.edge_type_i = 2'b11;

    // Back-to-back toggles with SYNC_STAGES = 0, then a mask change
    // between two edges.
    tbl[0] = '{a: 1'b1, m: 2'b11, r: 1'b1, f: 1'b0};
    tbl[1] = '{a: 1'b0, m: 2'b11, r: 1'b0, f: 1'b1};
    tbl[2] = '{a: 1'b1, m: 2'b11, r: 1'b1, f: 1'b0};
    tbl[3] = '{a: 1'b1, m: 2'b11, r: 1'b0, f: 1'b0};
    tbl[4] = '{a: 1'b0, m: 2'b11, r: 1'b0, f: 1'b1};
    tbl[5] = '{a: 1'b1, m: 2'b01, r: 1'b1, f: 1'b0};
    tbl[6] = '{a: 1'b0, m: 2'b01, r: 1'b0, f: 1'b0};

    @(negedge clk);
    // While reset is held, a_i toggles and both outputs must stay 0.
    for (int i = 0; i < 6; i++) begin
      step(i[0], 2'b11);
      chk("rst_rise0", bus0.rising_edge_o, 1'b0);
      chk("rst_rise2", bus2.rising_edge_o, 1'b0);
      chk("rst_fall2", bus2.falling_edge_o, 1'b0);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 2'b11);
      chk("post_rst_rise2", bus2.rising_edge_o, 1'b0);
      chk("post_rst_fall0", bus0.falling_edge_o, 1'b0);
    end

    // Table vectors.
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].a, tbl[i].m);
      chk($sformatf("tbl%0d_rise0", i), bus0.rising_edge_o,  tbl[i].r);
      chk($sformatf("tbl%0d_fall0", i), bus0.falling_edge_o, tbl[i].f);
    end

    // Rise/fall latency with every mask value.
    run_pattern(2'b11);
    run_pattern(2'b01);
    run_pattern(2'b10);
    run_pattern(2'b00);

    // Reset asserted while rising_edge_o is high must clear it at once.
    settle_low(2'b11);
    for (int c = 0; c < 3; c++) step(1'b1, 2'b11);
    chk("midpulse_rise2_before", bus2.rising_edge_o, 1'b1);
    #1 reset = 1'b1;
    #1 chk("midpulse_rise2_async", bus2.rising_edge_o, 1'b0);
    chk("midpulse_rise0_async", bus0.rising_edge_o, 1'b0);
    bus0.a_i = 1'b0;
    bus2.a_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_model();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 2'b11);
      chk("midpulse_no_rise2", bus2.rising_edge_o, 1'b0);
    end

    // a_i high through reset release gives exactly one pulse, two posedges
    // after the first post-reset posedge.
    reset = 1'b1;
    for (int i = 0; i < 2; i++) step(1'b1, 2'b11);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 2'b11);
      chk($sformatf("hi_rel_rise2_c%0d", c), bus2.rising_edge_o, c == 2);
      chk($sformatf("hi_rel_rise0_c%0d", c), bus0.rising_edge_o, c == 0);
    end

    // Random level and mask, with occasional resets, against the model.
    m = 2'b11;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) m = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b1;
        step(1'($urandom_range(0, 1)), m);
        reset = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        step(~bus0.a_i, m);
      end else begin
        step(1'($urandom_range(0, 1)), m);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
